// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-search scheduler.
package arc4_pkg;

    localparam int DEFAULT_KEY_WIDTH = 24;

    localparam logic [7:0] CHAR_MIN = 8'h20;
    localparam logic [7:0] CHAR_MAX = 8'h7E;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KSA,
        S_DEC,
        S_CHECK,
        S_DONE
    } ks_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_DEC
    } owner_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CHAR_MIN) && (b <= CHAR_MAX);
    endfunction

endpackage

// File: rtl/arc4_key_search_s_port_arb.sv
// Combinational 3-way S-memory port mux; the selected engine drives the port,
// everything is parked at zero when no engine owns it.
module s_port_arb
    import arc4_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  owner_t                i_owner,
    input  logic [ADDR_WIDTH-1:0] i_init_addr,
    input  logic [DATA_WIDTH-1:0] i_init_data,
    input  logic                  i_init_wren,
    input  logic [ADDR_WIDTH-1:0] i_ksa_addr,
    input  logic [DATA_WIDTH-1:0] i_ksa_data,
    input  logic                  i_ksa_wren,
    input  logic [ADDR_WIDTH-1:0] i_dec_addr,
    input  logic [DATA_WIDTH-1:0] i_dec_data,
    input  logic                  i_dec_wren,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_wren
);

    always_comb begin
        o_addr = '0;
        o_data = '0;
        o_wren = 1'b0;
        case (i_owner)
            OWN_INIT: begin
                o_addr = i_init_addr;
                o_data = i_init_data;
                o_wren = i_init_wren;
            end
            OWN_KSA: begin
                o_addr = i_ksa_addr;
                o_data = i_ksa_data;
                o_wren = i_ksa_wren;
            end
            OWN_DEC: begin
                o_addr = i_dec_addr;
                o_data = i_dec_data;
                o_wren = i_dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_key_search.sv
// ARC4 key-search scheduler: runs init -> ksa -> decrypt per candidate key,
// arbitrates the shared S port and accepts a key whose plaintext is all printable.
module arc4_key_search
    import arc4_pkg::*;
#(
    parameter int KEY_WIDTH   = DEFAULT_KEY_WIDTH,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MESSAGE_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  finish,
    output logic                  key_found,
    output logic [KEY_WIDTH-1:0]  key,
    output logic                  init_start,
    output logic                  ksa_start,
    output logic                  dec_start,
    input  logic                  init_finish,
    input  logic                  ksa_finish,
    input  logic                  dec_finish,
    input  logic [ADDR_WIDTH-1:0] init_s_addr,
    input  logic [DATA_WIDTH-1:0] init_s_data,
    input  logic                  init_s_wren,
    input  logic [ADDR_WIDTH-1:0] ksa_s_addr,
    input  logic [DATA_WIDTH-1:0] ksa_s_data,
    input  logic                  ksa_s_wren,
    input  logic [ADDR_WIDTH-1:0] dec_s_addr,
    input  logic [DATA_WIDTH-1:0] dec_s_data,
    input  logic                  dec_s_wren,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_wren,
    input  logic                  dec_result_wren,
    input  logic [DATA_WIDTH-1:0] dec_result_data
);

    ks_state_t            r_state;
    ks_state_t            w_next;
    owner_t               w_owner;
    logic [KEY_WIDTH-1:0] r_key;
    logic                 r_found;
    logic                 r_init_start;
    logic                 r_ksa_start;
    logic                 r_dec_start;
    logic [5:0]           r_wcnt;
    logic                 r_bad;
    logic                 w_pass;
    logic                 w_accept_start;

    assign w_pass         = !r_bad && (int'(r_wcnt) == MESSAGE_LEN);
    assign w_accept_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)       w_next = S_INIT;
            S_INIT:         if (init_finish) w_next = S_KSA;
            S_KSA:          if (ksa_finish)  w_next = S_DEC;
            S_DEC:          if (dec_finish)  w_next = S_CHECK;
            S_CHECK:        w_next = (w_pass || (r_key == '1)) ? S_DONE : S_INIT;
            default:        w_next = S_IDLE;
        endcase
    end

    // Starts decode the registered state, so each rises one cycle after entry
    // and drops one cycle after the engine's finish is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_found      <= 1'b0;
            r_init_start <= 1'b0;
            r_ksa_start  <= 1'b0;
            r_dec_start  <= 1'b0;
            r_wcnt       <= '0;
            r_bad        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_init_start <= (r_state == S_INIT);
            r_ksa_start  <= (r_state == S_KSA);
            r_dec_start  <= (r_state == S_DEC);

            if (w_accept_start) begin
                r_key   <= '0;
                r_found <= 1'b0;
            end else if (r_state == S_CHECK) begin
                if (w_pass)
                    r_found <= 1'b1;
                else if (r_key != '1)
                    r_key <= r_key + KEY_WIDTH'(1);
            end

            if ((r_state == S_KSA) && ksa_finish) begin
                r_wcnt <= '0;
                r_bad  <= 1'b0;
            end else if ((r_state == S_DEC) && dec_result_wren) begin
                if (r_wcnt != '1)
                    r_wcnt <= r_wcnt + 6'd1;
                if (!is_printable(dec_result_data[7:0]))
                    r_bad <= 1'b1;
            end
        end
    end

    always_comb begin
        w_owner = OWN_NONE;
        case (r_state)
            S_INIT:  w_owner = OWN_INIT;
            S_KSA:   w_owner = OWN_KSA;
            S_DEC:   w_owner = OWN_DEC;
            default: w_owner = OWN_NONE;
        endcase
    end

    s_port_arb #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_arb (
        .i_owner     (w_owner),
        .i_init_addr (init_s_addr),
        .i_init_data (init_s_data),
        .i_init_wren (init_s_wren),
        .i_ksa_addr  (ksa_s_addr),
        .i_ksa_data  (ksa_s_data),
        .i_ksa_wren  (ksa_s_wren),
        .i_dec_addr  (dec_s_addr),
        .i_dec_data  (dec_s_data),
        .i_dec_wren  (dec_s_wren),
        .o_addr      (s_addr),
        .o_data      (s_data),
        .o_wren      (s_wren)
    );

    assign finish     = (r_state == S_DONE);
    assign key_found  = r_found;
    assign key        = r_key;
    assign init_start = r_init_start;
    assign ksa_start  = r_ksa_start;
    assign dec_start  = r_dec_start;

endmodule
